// File: rtl/sys_time_idx_generator_pkg.sv
// sys_time_idx_generator_pkg: shared widths, settings limits and loop states for the index generator.
package sys_time_idx_generator_pkg;
    localparam int SYS_TIME_WIDTH = 61;
    localparam int DIV_WIDTH      = 32;
    localparam int IDX_WIDTH      = 16;
    localparam logic [DIV_WIDTH-1:0] FREQ_DIV_MIN = 32'd512;
    typedef enum logic [1:0] {IDLE, DIV_Q, DIV_M, OUT} state_e;
endpackage

// File: rtl/sys_time_idx_generator_iter_divider.sv
// iter_divider: restoring unsigned divider, one quotient bit per cycle, DONE exactly N_WIDTH cycles after START.
module iter_divider #(
    parameter int N_WIDTH = 61,
    parameter int D_WIDTH = 32
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    input  logic [N_WIDTH-1:0] N,
    input  logic [D_WIDTH-1:0] D,
    output logic [N_WIDTH-1:0] QUOT,
    output logic [D_WIDTH-1:0] REM,
    output logic               DONE
);
    localparam int CW = $clog2(N_WIDTH + 1);
    logic [N_WIDTH-1:0] n_q, n_d;
    logic [D_WIDTH-1:0] r_q, r_d, d_q, d_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [D_WIDTH:0]   r_sh, r_sub;
    logic               ge;
    // QUOT/REM show the result of the step taken this cycle, so they are final while DONE is high
    always_comb begin
        r_sh  = {r_q, n_q[N_WIDTH-1]};
        r_sub = r_sh - {1'b0, d_q};
        ge    = r_sh >= {1'b0, d_q};
        QUOT  = {n_q[N_WIDTH-2:0], ge};
        REM   = ge ? D_WIDTH'(r_sub) : D_WIDTH'(r_sh);
        DONE  = cnt_q == CW'(1);
        n_d   = n_q;
        r_d   = r_q;
        d_d   = d_q;
        cnt_d = cnt_q;
        if (START) begin
            n_d   = N;
            r_d   = '0;
            d_d   = D;
            cnt_d = CW'(N_WIDTH);
        end else if (cnt_q != '0) begin
            n_d   = QUOT;
            r_d   = REM;
            cnt_d = cnt_q - CW'(1);
        end
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            n_q   <= '0;
            r_q   <= '0;
            d_q   <= '0;
            cnt_q <= '0;
        end else begin
            n_q   <= n_d;
            r_q   <= r_d;
            d_q   <= d_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/sys_time_idx_generator.sv
// sys_time_idx_generator: IDX = (SYS_TIME / FREQ_DIV) mod (CYCLE+1), recomputed every 124 cycles
// with one shared iterative divider so all devices on the same SYS_TIME step in lockstep.
module sys_time_idx_generator
    import sys_time_idx_generator_pkg::*;
(
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [SYS_TIME_WIDTH-1:0] SYS_TIME,
    input  logic                      UPDATE_SETTINGS,
    input  logic [DIV_WIDTH-1:0]      FREQ_DIV,
    input  logic [IDX_WIDTH-1:0]      CYCLE,
    output logic [IDX_WIDTH-1:0]      IDX,
    output logic                      IDX_VALID,
    output logic                      IDX_CHANGED,
    output logic                      BUSY
);
    state_e                    state_q, state_d;
    logic [IDX_WIDTH-1:0]      idx_q, idx_d, rem_q, rem_d, cycle_q, cycle_d, sh_cycle_q, sh_cycle_d;
    logic [DIV_WIDTH-1:0]      sh_fdiv_q, sh_fdiv_d;
    logic                      valid_q, valid_d, changed_q, changed_d;
    logic                      div_start, div_done;
    logic [SYS_TIME_WIDTH-1:0] div_n, div_quot;
    logic [DIV_WIDTH-1:0]      div_d, div_rem, modulus;
    logic [IDX_WIDTH:0]        cycle_p1;

    iter_divider #(.N_WIDTH(SYS_TIME_WIDTH), .D_WIDTH(DIV_WIDTH)) u_div (
        .CLK(CLK), .RST(RST), .START(div_start), .N(div_n), .D(div_d),
        .QUOT(div_quot), .REM(div_rem), .DONE(div_done)
    );

    assign cycle_p1    = {1'b0, cycle_q} + (IDX_WIDTH + 1)'(1);
    assign modulus     = DIV_WIDTH'(cycle_p1);
    assign IDX         = idx_q;
    assign IDX_VALID   = valid_q;
    assign IDX_CHANGED = changed_q;
    assign BUSY        = state_q != IDLE;

    // The divider latches its divisor at START, so it holds the active FREQ_DIV for the whole pass
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rem_d      = rem_q;
        cycle_d    = cycle_q;
        sh_fdiv_d  = sh_fdiv_q;
        sh_cycle_d = sh_cycle_q;
        valid_d    = 1'b0;
        changed_d  = 1'b0;
        div_start  = 1'b0;
        div_n      = SYS_TIME;
        div_d      = sh_fdiv_q;
        if (UPDATE_SETTINGS && FREQ_DIV >= FREQ_DIV_MIN) begin
            sh_fdiv_d  = FREQ_DIV;
            sh_cycle_d = CYCLE;
        end
        case (state_q)
            IDLE: begin
                div_start = 1'b1;
                cycle_d   = sh_cycle_q;
                state_d   = DIV_Q;
            end
            DIV_Q: begin
                div_start = div_done;
                div_n     = div_quot;
                div_d     = modulus;
                state_d   = div_done ? DIV_M : DIV_Q;
            end
            DIV_M: begin
                rem_d   = div_done ? IDX_WIDTH'(div_rem) : rem_q;
                state_d = div_done ? OUT : DIV_M;
            end
            default: begin
                idx_d     = rem_q;
                valid_d   = 1'b1;
                changed_d = rem_q != idx_q;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            rem_q      <= '0;
            cycle_q    <= '0;
            sh_fdiv_q  <= FREQ_DIV_MIN;
            sh_cycle_q <= '0;
            valid_q    <= 1'b0;
            changed_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rem_q      <= rem_d;
            cycle_q    <= cycle_d;
            sh_fdiv_q  <= sh_fdiv_d;
            sh_cycle_q <= sh_cycle_d;
            valid_q    <= valid_d;
            changed_q  <= changed_d;
        end
    end
endmodule

// File: doc/sys_time_idx_generator.md
Name: sys_time_idx_generator

Overview:
- Sits directly downstream of synchronizer and consumes its 61-bit SYS_TIME, which counts CLK ticks and is aligned to ECAT_SYNC.
- Converts SYS_TIME into a sampling index: IDX = (SYS_TIME / FREQ_DIV) mod (CYCLE + 1).
- Every device sharing the same SYS_TIME and settings outputs the same index, so the modulation and STM stages step in lockstep.
- Uses one time-multiplexed iterative divider instead of a combinational 61-bit divide.

Parameters:
- SYS_TIME_WIDTH, 61, width of SYS_TIME and of the quotient.
- DIV_WIDTH, 32, width of FREQ_DIV and of the internal divisor.
- IDX_WIDTH, 16, width of CYCLE and IDX.
- FREQ_DIV_MIN, 512, smallest accepted FREQ_DIV.

Ports:
- CLK  in  1  system clock, same domain as synchronizer.
- RST  in  1  synchronous, active-high reset.
- SYS_TIME  in  61  synchronized system time from synchronizer.
- UPDATE_SETTINGS  in  1  one-cycle strobe; latch FREQ_DIV and CYCLE.
- FREQ_DIV  in  32  ticks per index step.
- CYCLE  in  16  last index value (IDX wraps after CYCLE).
- IDX  out  16  current index.
- IDX_VALID  out  1  one-cycle pulse when IDX is refreshed.
- IDX_CHANGED  out  1  one-cycle pulse coincident with IDX_VALID when the new IDX differs from the previous IDX.
- BUSY  out  1  high outside IDLE.

Behaviour:
- Clocking: one clock (CLK); reset RST is synchronous, active-high.
- Reset values:
  - IDX=0, IDX_VALID=0, IDX_CHANGED=0, BUSY=0.
  - Active FREQ_DIV=512, active CYCLE=0, shadow settings equal the active values.
  - State = IDLE.
- Settings:
  - On UPDATE_SETTINGS, FREQ_DIV and CYCLE are latched into shadow registers.
  - If FREQ_DIV < FREQ_DIV_MIN, the strobe is ignored entirely (CYCLE is not latched either).
  - Shadow values are copied to the active values only on the IDLE cycle. A computation in flight always completes with the old settings.
- State machine, free-running:
  - IDLE (1 cycle): snapshot SYS_TIME, copy shadow to active, start the divider with N=snapshot and D=FREQ_DIV → DIV_Q.
  - DIV_Q (61 cycles): restoring division, 1 quotient bit per cycle, MSB first. On done, restart the divider with N=quotient and D=zero-extended CYCLE+1 (17-bit value, range 1..65536) → DIV_M.
  - DIV_M (61 cycles): same divider; only the remainder is kept → OUT.
  - OUT (1 cycle): IDX ← remainder[15:0]; IDX_VALID=1; IDX_CHANGED=(remainder != old IDX) → IDLE.
- Timing:
  - Loop period is 124 cycles.
  - IDX and IDX_VALID become visible on the edge ending OUT, i.e. 123 cycles after the snapshot edge.
  - The first IDX_VALID pulse comes 124 cycles after RST deasserts.
- Arithmetic:
  - All division is unsigned. The remainder is always < CYCLE+1, so it fits in 16 bits.
  - CYCLE=0 gives IDX constantly 0; IDX_CHANGED never fires after the first refresh from 0.
- Boundaries:
  - SYS_TIME wrap at 2^61 needs no special handling; the snapshot is used as-is.
  - A jump in SYS_TIME (synchronizer resync) takes effect on the next snapshot; there is no smoothing.
  - RST during any state aborts the divider and returns to the reset values the following cycle.
  - UPDATE_SETTINGS coinciding with the IDLE cycle: the new values are used by the next loop, not the current one.

Decomposition:
- Shared package (settings / params): FREQ_DIV_MIN, SYS_TIME_WIDTH, and the state enum {IDLE, DIV_Q, DIV_M, OUT}.
- Sub-module iter_divider, parameters N_WIDTH=61 and D_WIDTH=32.
  - Ports: CLK, RST, START, N, D, QUOT, REM, DONE.
  - Fixed latency of N_WIDTH cycles from START to DONE.
  - One instance is reused for both passes.

Test Plan:
- FREQ_DIV=512, CYCLE=3, SYS_TIME held at 2048 → IDX=0. Then SYS_TIME held at 512*5+7 → IDX=1 with IDX_CHANGED=1.
- SYS_TIME=2^61-1, FREQ_DIV=512, CYCLE=65535 → quotient 2^52-1, IDX=65535.
- Free-running SYS_TIME from 0, FREQ_DIV=1024, CYCLE=9 → IDX_VALID period is exactly 124 cycles. IDX follows floor(snapshot/1024) mod 10, matching a reference model on every pulse.
- UPDATE_SETTINGS with FREQ_DIV=100 → ignored, IDX unchanged. UPDATE_SETTINGS with CYCLE=0 during DIV_Q → the current result still uses the old CYCLE; the next IDX=0.
- RST asserted mid-DIV_M for 1 cycle → next cycle IDX=0 and BUSY=0. First IDX_VALID comes 124 cycles after release.
- Two instances fed SYS_TIME that differs only at sub-FREQ_DIV granularity (+/-50 ppm clocks, shared ECAT_SYNC) → IDX streams identical except at step boundaries, mismatch ≤1 index.
